sipo_frame_controller: RTL and testbench

Sequencer that drives a DATA_WIDTH-bit serial-in-parallel-out shift register. It accepts a frame start, gates serial bits into the shift register one per valid cycle, and counts them. After DATA_WIDTH bits it captures the parallel word and presents it on a valid/ready output port. It sits between a bit-serial source and any word-wide consumer.

---
 rtl/sipo_frame_controller_pkg.sv | 15 +
 rtl/sipo_bit_counter.sv | 37 +++
 rtl/sipo_frame_controller.sv | 129 ++++++++++++
 tb/tb_sipo_frame_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_controller_pkg.sv
// Shared types and helpers for the SIPO frame controller and its bit counter.
package sipo_frame_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic int counter_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: synchronous clear, increment, and terminal count at DATA_WIDTH-1.
module sipo_bit_counter
  import sipo_frame_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = counter_width(DATA_WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/sipo_frame_controller.sv
// Frame sequencer for an external SIPO shift register: gates serial bits in,
// captures the parallel word after DATA_WIDTH bits and offers it on a valid/ready port.
module sipo_frame_controller
  import sipo_frame_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic                  Abort_In,
  input  logic                  Serial_Valid_In,
  input  logic                  Serial_Data_In,
  output logic                  Sipo_Enable_Out,
  output logic                  Sipo_Shift_Out,
  output logic                  Sipo_Serial_Data_Out,
  input  logic [DATA_WIDTH-1:0] Sipo_Parallel_Data_In,
  output logic [DATA_WIDTH-1:0] Word_Data_Out,
  output logic                  Word_Valid_Out,
  input  logic                  Word_Ready_In,
  output logic                  Busy_Out,
  output logic                  Overrun_Out,
  input  logic                  Clear_Error_In,
  output state_t                State_Dbg_Out
);

  // Word port: a word transfers on a rising edge where Word_Valid_Out and
  // Word_Ready_In are both high; once raised, valid and data stay stable until then.

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  cnt_clr, cnt_inc, cnt_tc;
  logic                  overrun_set;

  sipo_bit_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_counter (
    .clk_i (Clk_In),
    .rst_ni(Reset_In),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        // Abort wins even over the final bit of the frame.
        if (Abort_In) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (Serial_Valid_In) begin
          if (cnt_tc) begin
            state_d = CAPTURE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        word_d  = Sipo_Parallel_Data_In;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (Word_Ready_In) begin
          valid_d = 1'b0;
          if (Start_In) begin
            state_d = SHIFT;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A bit arriving outside SHIFT is dropped and flagged; set beats clear.
  assign overrun_set = Serial_Valid_In && (state_q != SHIFT);

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (Clear_Error_In) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q   <= IDLE;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign Sipo_Enable_Out      = (state_q == SHIFT) || (state_q == CAPTURE);
  assign Sipo_Shift_Out       = (state_q == SHIFT) && Serial_Valid_In;
  assign Sipo_Serial_Data_Out = (state_q == SHIFT) && Serial_Data_In;
  assign Word_Data_Out        = word_q;
  assign Word_Valid_Out       = valid_q;
  assign Busy_Out             = (state_q != IDLE);
  assign Overrun_Out          = overrun_q;
  assign State_Dbg_Out        = state_q;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller driving a behavioural 4-bit SIPO register.
module tb_sipo_frame_controller;
  import sipo_frame_controller_pkg::*;

  localparam int W = 4;

  logic         Clk_In = 1'b0;
  logic         Reset_In = 1'b0;
  logic         Start_In = 1'b0;
  logic         Abort_In = 1'b0;
  logic         Serial_Valid_In = 1'b0;
  logic         Serial_Data_In = 1'b0;
  logic         Sipo_Enable_Out;
  logic         Sipo_Shift_Out;
  logic         Sipo_Serial_Data_Out;
  logic [W-1:0] Sipo_Parallel_Data_In;
  logic [W-1:0] Word_Data_Out;
  logic         Word_Valid_Out;
  logic         Word_Ready_In = 1'b0;
  logic         Busy_Out;
  logic         Overrun_Out;
  logic         Clear_Error_In = 1'b0;
  state_t       State_Dbg_Out;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 Clk_In = ~Clk_In;

  // behavioural SIPO: first bit shifted in ends up in the MSB
  logic [W-1:0] sipo_q;
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) sipo_q <= '0;
    else if (Sipo_Enable_Out && Sipo_Shift_Out) sipo_q <= {sipo_q[W-2:0], Sipo_Serial_Data_Out};
  end
  assign Sipo_Parallel_Data_In = sipo_q;

  sipo_frame_controller #(.DATA_WIDTH(W)) dut (
    .Clk_In               (Clk_In),
    .Reset_In             (Reset_In),
    .Start_In             (Start_In),
    .Abort_In             (Abort_In),
    .Serial_Valid_In      (Serial_Valid_In),
    .Serial_Data_In       (Serial_Data_In),
    .Sipo_Enable_Out      (Sipo_Enable_Out),
    .Sipo_Shift_Out       (Sipo_Shift_Out),
    .Sipo_Serial_Data_Out (Sipo_Serial_Data_Out),
    .Sipo_Parallel_Data_In(Sipo_Parallel_Data_In),
    .Word_Data_Out        (Word_Data_Out),
    .Word_Valid_Out       (Word_Valid_Out),
    .Word_Ready_In        (Word_Ready_In),
    .Busy_Out             (Busy_Out),
    .Overrun_Out          (Overrun_Out),
    .Clear_Error_In       (Clear_Error_In),
    .State_Dbg_Out        (State_Dbg_Out)
  );

  // driver tasks
  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic start_frame();
    Start_In = 1'b1;
    tick();
    Start_In = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    Serial_Valid_In = 1'b1;
    Serial_Data_In  = b;
    tick();
    Serial_Valid_In = 1'b0;
    Serial_Data_In  = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    Reset_In = 1'b0;
    tick();
    tick();
    checks++;
    if (Busy_Out !== 1'b0 || Word_Valid_Out !== 1'b0 || Overrun_Out !== 1'b0 || Word_Data_Out !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b overrun=%b word=%h, expected 0 0 0 0",
               Busy_Out, Word_Valid_Out, Overrun_Out, Word_Data_Out);
    end
    checks++;
    if (Sipo_Enable_Out !== 1'b0 || Sipo_Shift_Out !== 1'b0 || State_Dbg_Out !== IDLE) begin
      errors++;
      $display("FAIL reset_sipo_ctrl: en=%b shift=%b state=%0d, expected 0 0 0",
               Sipo_Enable_Out, Sipo_Shift_Out, State_Dbg_Out);
    end
    Reset_In = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    Word_Ready_In = 1'b1;
    start_frame();
    checks++;
    if (Busy_Out !== 1'b1 || Sipo_Enable_Out !== 1'b1 || State_Dbg_Out !== SHIFT) begin
      errors++;
      $display("FAIL basic_enter_shift: busy=%b en=%b state=%0d, expected 1 1 1",
               Busy_Out, Sipo_Enable_Out, State_Dbg_Out);
    end
    Serial_Valid_In = 1'b1;
    Serial_Data_In  = 1'b1;
    #1;
    checks++;
    if (Sipo_Shift_Out !== 1'b1 || Sipo_Serial_Data_Out !== 1'b1) begin
      errors++;
      $display("FAIL basic_forward: shift=%b data=%b, expected 1 1", Sipo_Shift_Out, Sipo_Serial_Data_Out);
    end
    tick();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (State_Dbg_Out !== CAPTURE || Word_Valid_Out !== 1'b0 || Sipo_Enable_Out !== 1'b1 || Sipo_Shift_Out !== 1'b0) begin
      errors++;
      $display("FAIL basic_capture: state=%0d valid=%b en=%b shift=%b, expected 2 0 1 0",
               State_Dbg_Out, Word_Valid_Out, Sipo_Enable_Out, Sipo_Shift_Out);
    end
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'hB || Sipo_Enable_Out !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: valid=%b word=%h en=%b, expected 1 b 0",
               Word_Valid_Out, Word_Data_Out, Sipo_Enable_Out);
    end
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b0 || Busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: valid=%b busy=%b, expected 0 0", Word_Valid_Out, Busy_Out);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bits;
    bits = 4'h6;
    Word_Ready_In = 1'b0;
    start_frame();
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(bits[i]);
      if (i != 0) begin
        tick();
        tick();
      end
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'h6) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b word=%h, expected 1 6", c, Word_Valid_Out, Word_Data_Out);
      end
      tick();
    end
    Word_Ready_In = 1'b1;
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b0 || Busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: valid=%b busy=%b, expected 0 0", Word_Valid_Out, Busy_Out);
    end
  endtask

  task automatic test_back_to_back();
    Word_Ready_In = 1'b1;
    start_frame();
    send_word(4'h9);
    Start_In = 1'b1;
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'h9) begin
      errors++;
      $display("FAIL b2b_first: valid=%b word=%h, expected 1 9", Word_Valid_Out, Word_Data_Out);
    end
    tick();
    Start_In = 1'b0;
    checks++;
    if (State_Dbg_Out !== SHIFT || Busy_Out !== 1'b1 || Word_Valid_Out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: state=%0d busy=%b valid=%b, expected 1 1 0",
               State_Dbg_Out, Busy_Out, Word_Valid_Out);
    end
    send_word(4'h3);
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'h3) begin
      errors++;
      $display("FAIL b2b_second: valid=%b word=%h, expected 1 3", Word_Valid_Out, Word_Data_Out);
    end
    tick();
  endtask

  task automatic test_overrun();
    Word_Ready_In = 1'b0;
    start_frame();
    send_word(4'hA);
    tick();
    checks++;
    if (Overrun_Out !== 1'b0 || State_Dbg_Out !== HOLD) begin
      errors++;
      $display("FAIL overrun_pre: overrun=%b state=%0d, expected 0 3", Overrun_Out, State_Dbg_Out);
    end
    send_bit(1'b1);
    checks++;
    if (Overrun_Out !== 1'b1 || Word_Data_Out !== 4'hA || Word_Valid_Out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: overrun=%b word=%h valid=%b, expected 1 a 1",
               Overrun_Out, Word_Data_Out, Word_Valid_Out);
    end
    Clear_Error_In = 1'b1;
    tick();
    Clear_Error_In = 1'b0;
    checks++;
    if (Overrun_Out !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, expected 0", Overrun_Out);
    end
    Clear_Error_In = 1'b1;
    send_bit(1'b0);
    Clear_Error_In = 1'b0;
    checks++;
    if (Overrun_Out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun=%b, expected 1", Overrun_Out);
    end
    Clear_Error_In = 1'b1;
    Word_Ready_In  = 1'b1;
    tick();
    Clear_Error_In = 1'b0;
    send_bit(1'b1);
    checks++;
    if (Overrun_Out !== 1'b1 || Busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL overrun_idle: overrun=%b busy=%b, expected 1 0", Overrun_Out, Busy_Out);
    end
    Clear_Error_In = 1'b1;
    tick();
    Clear_Error_In = 1'b0;
  endtask

  task automatic test_abort();
    Word_Ready_In = 1'b1;
    start_frame();
    send_bit(1'b1);
    send_bit(1'b1);
    Abort_In = 1'b1;
    tick();
    Abort_In = 1'b0;
    checks++;
    if (State_Dbg_Out !== IDLE || Busy_Out !== 1'b0 || Word_Valid_Out !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: state=%0d busy=%b valid=%b, expected 0 0 0",
               State_Dbg_Out, Busy_Out, Word_Valid_Out);
    end
    start_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    Abort_In = 1'b1;
    send_bit(1'b1);
    Abort_In = 1'b0;
    tick();
    checks++;
    if (State_Dbg_Out !== IDLE || Word_Valid_Out !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: state=%0d valid=%b, expected 0 0", State_Dbg_Out, Word_Valid_Out);
    end
    start_frame();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (State_Dbg_Out !== SHIFT) begin
      errors++;
      $display("FAIL abort_counter_restart: state=%0d, expected 1", State_Dbg_Out);
    end
    send_bit(1'b1);
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'hF) begin
      errors++;
      $display("FAIL abort_next_frame: valid=%b word=%h, expected 1 f", Word_Valid_Out, Word_Data_Out);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    Word_Ready_In = 1'b1;
    send_bit(1'b1);
    start_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    Reset_In = 1'b0;
    #1;
    checks++;
    if (Busy_Out !== 1'b0 || Sipo_Enable_Out !== 1'b0 || Word_Data_Out !== 4'h0 ||
        Overrun_Out !== 1'b0 || Word_Valid_Out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: busy=%b en=%b word=%h overrun=%b valid=%b, expected 0 0 0 0 0",
               Busy_Out, Sipo_Enable_Out, Word_Data_Out, Overrun_Out, Word_Valid_Out);
    end
    #2;
    Reset_In = 1'b1;
    tick();
    start_frame();
    send_word(4'hC);
    tick();
    checks++;
    if (Word_Valid_Out !== 1'b1 || Word_Data_Out !== 4'hC) begin
      errors++;
      $display("FAIL reset_next_frame: valid=%b word=%h, expected 1 c", Word_Valid_Out, Word_Data_Out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
